// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with its own storage array.
// Provides occupancy count, almost-full/almost-empty thresholds, sticky
// overflow/underflow flags, and either registered or first-word-fall-through
// read presentation.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 4,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Thresholds sized to the counter so comparisons are width-matched.
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_C    = AF_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_C    = AE_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags come only from the registered count, so a request never
    // sees its own effect in the same cycle (full blocks write even with
    // a concurrent read, empty blocks read even with a concurrent write).
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Storage write; the array itself is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // Pointer and occupancy update; extra MSB on pointers tracks wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ONE_C;
            if (rd_acc) rd_ptr <= rd_ptr + ONE_C;
            if (wr_acc && !rd_acc) begin
                count <= count + ONE_C;
            end else if (rd_acc && !wr_acc) begin
                count <= count - ONE_C;
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full)  overflow  <= 1'b1;
            else if (clr_err)   overflow  <= 1'b0;
            if (rd_en && empty) underflow <= 1'b1;
            else if (clr_err)   underflow <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally; rd_en just pops it.
            assign rd_data  = empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
            assign rd_valid = !empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            // Registered read: data captured on the popping edge, held otherwise.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO that wraps its own dual-port storage array with pointer and flag logic, replacing the bare RAM-plus-external-control arrangement in the FIFO datapath. It adds an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. A selectable first-word-fall-through (FWFT) read mode is also provided. It sits between a producer and a consumer in the same clock domain.

## Interface
- DATA_WIDTH, 8, width of each stored word
- ADDR_WIDTH, 4, address bits; DEPTH = 2^ADDR_WIDTH words
- AF_THRESH, DEPTH-4, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- rd_en  in  1  read (pop) request
- rd_data  out  DATA_WIDTH  read word
- rd_valid  out  1  rd_data is valid
- full / empty  out  1 each  occupancy == DEPTH / == 0
- almost_full / almost_empty  out  1 each  threshold flags
- count  out  ADDR_WIDTH+1  words stored, 0..DEPTH
- overflow / underflow  out  1 each  sticky error flags
- clr_err  in  1  synchronous clear of overflow and underflow

## Operation
- Pointers wr_ptr/rd_ptr are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits address storage, and the MSB tracks wrap. The pointers wrap naturally from DEPTH*2-1 to 0.
- count is a registered counter. All flags are combinational from the registered count only, never from the current-cycle requests.
  - full = (count == DEPTH); empty = (count == 0)
  - almost_full = (count >= AF_THRESH); almost_empty = (count <= AE_THRESH)
- Write acceptance: wr_acc = wr_en && !full. An accepted write stores the word at mem[wr_ptr] and increments wr_ptr.
- Read acceptance: rd_acc = rd_en && !empty. An accepted read increments rd_ptr.
- Count update: count += wr_acc - rd_acc.
  - Simultaneous accepted read and write leaves count unchanged.
  - When full, a simultaneous rd_en does not allow the write in the same cycle; the write is rejected.
  - When empty, a simultaneous wr_en does not allow the read in the same cycle; the read is rejected.
- Standard mode (FWFT=0):
  - On rd_acc, rd_data is registered from mem[rd_ptr] and rd_valid pulses high for one cycle.
  - Otherwise rd_data holds its last value and rd_valid is 0.
- FWFT mode:
  - rd_data = mem[rd_ptr] through a combinational read whenever !empty, and is forced to 0 when empty.
  - rd_valid = !empty.
  - rd_en acts as acknowledge/pop of the presented word.
- Error flags:
  - overflow sets on wr_en && full.
  - underflow sets on rd_en && empty.
  - Both clear on clr_err; a set condition in the same cycle as clr_err wins.
- Rejected requests change no pointer, count or storage.
- The storage array is not reset; only control state and outputs are.

## Timing
- Reset values: count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0; both pointers 0.
- Assertion of rst_n low mid-operation discards all contents immediately, without waiting for a clock edge.
- Write latency: a write accepted at edge N updates count and flags after edge N.
  - In FWFT, that word is visible on rd_data in the cycle following edge N.
- Read latency:
  - Standard mode: rd_data and rd_valid are valid in the cycle after the accepting edge (1-cycle latency).
  - FWFT: the next word appears in the cycle following the popping edge.
- Flag timing: full deasserts in the cycle after the first accepted read from full, and empty deasserts in the cycle after the first accepted write from empty.
- Error flags are registered and assert in the cycle after the offending request.

## Test plan
- Reset, then 16 writes of 0x00..0x0F (DEPTH=16, AF=12, AE=2):
  - almost_empty drops when count reaches 3 and almost_full rises when count reaches 12.
  - full = 1 and count = 16 after the 16th write; overflow stays 0.
- Write 0xAA while full -> count stays 16, storage unchanged, overflow = 1 next cycle. Then clr_err -> overflow = 0.
- From full, drain in standard mode -> rd_data sequence 0x00..0x0F, each with a one-cycle rd_valid pulse one cycle after rd_en. empty = 1 after the last read.
  - One extra rd_en -> underflow = 1, rd_data holds 0x0F.
- Simultaneous rd_en/wr_en at count = 5 for 40 cycles, wrapping the pointers more than twice -> count stays 5 and output order is preserved.
- FWFT = 1, write 0x3C into an empty FIFO -> rd_data = 0x3C and rd_valid = 1 in the next cycle without rd_en. After rd_en -> empty = 1, rd_data = 0.
- Fill to 9 words, pulse rst_n low between clock edges -> all outputs at reset values immediately. A subsequent write/read of 0x55 returns 0x55.
